// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants, FSM encoding and Fermat-modulus helpers for the NTT datapath
// Modulus is Q = 2^K + 1 with K = LOGQ - 1.
package ntt_pkg;

  localparam int NTT_LOGQ = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RED  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int fermat_k(input int logq);
    return logq - 1;
  endfunction

endpackage

// File: rtl/modred_fold.sv
// rtl/modred_fold.sv - combinational 2*LOGQ to LOGQ reducer for Q = 2^K+1
// Uses 2^K == -1 (mod Q): x = hi*2^K + lo reduces to lo - hi, then one correction each way.
module modred_fold
  import ntt_pkg::*;
#(
  parameter int LOGQ = NTT_LOGQ
) (
  input  logic [2*LOGQ-1:0] x_i,
  output logic [LOGQ-1:0]   r_o
);

  localparam int K  = fermat_k(LOGQ);
  localparam int TW = 2*LOGQ + 2;

  function automatic logic [LOGQ-1:0] fold(input logic [2*LOGQ-1:0] x);
    logic signed [TW-1:0] lo, hi, q_s, t0, t1, t2;
    lo  = $signed({{(TW-K){1'b0}}, x[K-1:0]});
    hi  = $signed({{(TW-(2*LOGQ-K)){1'b0}}, x[2*LOGQ-1:K]});
    q_s = $signed({{(TW-LOGQ){1'b0}}, 1'b1, {(K-1){1'b0}}, 1'b1});
    t0  = lo - hi;
    t1  = (t0 < 0) ? t0 + q_s : t0;
    t2  = (t1 >= q_s) ? t1 - q_s : t1;
    return t2[LOGQ-1:0];
  endfunction

  always_comb begin
    r_o = fold(x_i);
  end

endmodule

// File: rtl/modmul_seq.sv
// rtl/modmul_seq.sv - sequential shift-add modular multiplier, s = a*b mod (2^(LOGQ-1)+1)
// MODMUL_EARLY_TERM_EN: leave MUL as soon as the remaining multiplier bits are all zero.
module modmul_seq
  import ntt_pkg::*;
#(
  parameter int LOGQ = NTT_LOGQ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LOGQ-1:0] a,
  input  logic [LOGQ-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] s
);

  localparam int PW = 2*LOGQ;
  localparam int CW = $clog2(LOGQ + 1);

  state_e          state_q;
  logic [PW-1:0]   a_q, acc_q, acc_d;
  logic [LOGQ-1:0] b_q, b_d, s_q, red_s;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, out_valid_q, mul_last;

  always_comb begin
    acc_d = b_q[0] ? acc_q + a_q : acc_q;
    b_d   = b_q >> 1;
    cnt_d = cnt_q - 1'b1;
`ifdef MODMUL_EARLY_TERM_EN
    mul_last = (cnt_d == '0) || (b_d == '0);
`else
    mul_last = (cnt_d == '0);
`endif
  end

  modred_fold #(.LOGQ(LOGQ)) u_fold (
    .x_i(acc_q),
    .r_o(red_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= {{LOGQ{1'b0}}, a};
            b_q        <= b;
            acc_q      <= '0;
            cnt_q      <= CW'(LOGQ);
            in_ready_q <= 1'b0;
            state_q    <= MUL;
          end
        end
        MUL: begin
          acc_q <= acc_d;
          a_q   <= a_q << 1;
          b_q   <= b_d;
          cnt_q <= cnt_d;
          if (mul_last) state_q <= RED;
        end
        RED: begin
          s_q         <= red_s;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;

endmodule

// File: doc/modmul_seq.md
MODMUL_SEQ -- requirements
Module: modmul_seq

Interface
REQ-001 SHALL have parameter LOGQ, default 17, the operand and result width; modulus Q = 2^(LOGQ-1)+1 and K = LOGQ-1.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, operand pair is valid.
REQ-005 SHALL have port in_ready, output, 1, block accepts an operand pair.
REQ-006 SHALL have port a, input, LOGQ, multiplicand, contract range 0..Q-1.
REQ-007 SHALL have port b, input, LOGQ, multiplier, contract range 0..Q-1.
REQ-008 SHALL have port out_valid, output, 1, result is valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port s, output, LOGQ, result (a*b) mod Q, in range 0..Q-1.

Function
REQ-011 SHALL implement the FSM states IDLE, MUL, RED and DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE; an operand pair is accepted on a clock edge with in_valid&&in_ready.
REQ-013 SHALL, on acceptance, latch a zero-extended to 2*LOGQ bits, latch b, clear the 2*LOGQ-bit accumulator, load the bit counter with LOGQ, and enter MUL.
REQ-014 SHALL, in MUL, perform one LSB-first shift-add per cycle: if b_reg[0] then acc += a_reg; then a_reg <<= 1, b_reg >>= 1, and decrement the counter.
REQ-015 SHALL leave MUL for RED on the edge where the counter reaches 0.
REQ-016 SHALL, in RED, apply one fold-and-correct reduction for Q = 2^K+1 to acc: t = acc[K-1:0] - acc[2*LOGQ-1:K]; if t<0 add Q; if t>=Q subtract Q.
REQ-017 SHALL, in RED, register the reduction result into s, set out_valid, and enter DONE.
REQ-018 SHALL, in DONE, hold s and out_valid stable until out_ready=1; then clear out_valid on that edge and return to IDLE.
REQ-019 SHALL give a fixed latency: out_valid rises LOGQ+1 edges after the accepting edge; minimum issue interval LOGQ+3 cycles with out_ready tied high.
REQ-020 SHALL ignore in_valid outside IDLE, with no queuing; a and b may change freely after acceptance.
REQ-021 SHALL map a=2^K, b=2^K to 1, and either operand 0 to 0; operands above Q-1 are outside contract and give an unspecified s, with no hang.
REQ-022 SHALL keep internal product width 2*LOGQ bits, with no overflow for in-contract operands.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, force IDLE, out_valid=0, s=0, in_ready=1 on the next cycle, and clear acc and the counter.
REQ-024 SHALL, on rst asserted mid-MUL, mid-RED or in DONE, abort the operation with no result emitted; rst has priority over all handshakes.

Configuration
REQ-025 SHALL support macro MODMUL_EARLY_TERM_EN; when defined, MUL transitions to RED on the edge where the post-shift b_reg is zero or the counter reaches 0, whichever is first, giving latency (index of highest set bit of b)+2 edges, and b=0 gives latency 2.
REQ-026 SHALL use the fixed latency of REQ-019 when MODMUL_EARLY_TERM_EN is not defined; the result value SHALL be identical in both builds.

Structure
REQ-027 SHALL take Q, K and the FSM state encodings from a shared package or include ntt_pkg, common to the NTT datapath.
REQ-028 SHALL place the RED-stage reduction in one sub-module, modred_fold, a combinational 2*LOGQ to LOGQ Fermat-form reducer, instantiated once; MUL and FSM stay in modmul_seq.

Verification (LOGQ=17, Q=65537)
REQ-029 SHALL cover basic multiply: a=3, b=5 with out_ready high -> s=15; out_valid rises 18 edges after acceptance in a non-EARLY_TERM build.
REQ-030 SHALL cover wrap-around: a=65536, b=65536 -> s=1; a=65536, b=2 -> s=65535; a=65536, b=65536 with the build reducing through t<0 -> s=1.
REQ-031 SHALL cover backpressure: out_ready low for 10 cycles after out_valid -> s and out_valid stable, in_ready=0 throughout; out_ready high -> IDLE next cycle.
REQ-032 SHALL cover mid-operation reset: rst pulsed 5 cycles after acceptance -> out_valid never rises for that pair; new pair a=7, b=9 then -> s=63.
REQ-033 SHALL cover early termination: with MODMUL_EARLY_TERM_EN, b=1 -> latency 2 edges; b=0 -> s=0; b=65536 -> latency 18 edges; random 10k pairs -> match a*b%65537 in both builds.
